// File: rtl/mlp_feature_scaler.sv
// Normalises a three-feature sample, (x - mean) * scale in signed fixed point,
// and presents the saturated triple as held MLP inputs with a one-cycle valid pulse.
module mlp_feature_scaler #(
    parameter int INTEGRAL_WIDTH = 4,
    parameter int FRACTION_WIDTH = 16,
    parameter logic signed [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] MEAN_1 = '0,
    parameter logic signed [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] MEAN_2 = '0,
    parameter logic signed [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] MEAN_3 = '0,
    parameter logic signed [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] SCALE_1 =
        {{(INTEGRAL_WIDTH-1){1'b0}}, 1'b1, {FRACTION_WIDTH{1'b0}}},
    parameter logic signed [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] SCALE_2 =
        {{(INTEGRAL_WIDTH-1){1'b0}}, 1'b1, {FRACTION_WIDTH{1'b0}}},
    parameter logic signed [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] SCALE_3 =
        {{(INTEGRAL_WIDTH-1){1'b0}}, 1'b1, {FRACTION_WIDTH{1'b0}}}
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic signed [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] in_data,
    input  logic                                           in_valid,
    input  logic                                           in_last,
    output logic                                           in_ready,
    output logic signed [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] inp_1,
    output logic signed [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] inp_2,
    output logic signed [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] inp_3,
    output logic                                           out_valid,
    output logic [2:0]                                     out_sat,
    output logic                                           frame_err
);
    localparam int W = INTEGRAL_WIDTH + FRACTION_WIDTH;
    localparam logic signed [2*W+1:0] MAX_V = {{(W+3){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W+1:0] MIN_V = {{(W+3){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {COLLECT, SCALE, EMIT} state_t;

    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic signed [W-1:0]  raw_q [3];
    logic signed [W-1:0]  res_q [2];
    logic [1:0]           part_sat_q;
    logic signed [W-1:0]  inp1_q, inp2_q, inp3_q;
    logic [2:0]           out_sat_q;
    logic                 out_valid_q;
    logic                 frame_err_q, frame_err_d;
    logic                 accept, store_en;

    logic signed [W-1:0]   sel_raw, sel_mean, sel_scale, res_w;
    logic signed [W:0]     diff_w;
    logic signed [2*W+1:0] prod_w, shr_w;
    logic                  sat_w;

    assign in_ready  = (state_q == COLLECT) && !rst;
    assign accept    = in_valid && in_ready;
    assign inp_1     = inp1_q;
    assign inp_2     = inp2_q;
    assign inp_3     = inp3_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;

    // Single shared datapath: idx selects which feature is scaled this cycle.
    always_comb begin
        sel_raw   = raw_q[2];
        sel_mean  = MEAN_3;
        sel_scale = SCALE_3;
        case (idx_q)
            2'd0: begin sel_raw = raw_q[0]; sel_mean = MEAN_1; sel_scale = SCALE_1; end
            2'd1: begin sel_raw = raw_q[1]; sel_mean = MEAN_2; sel_scale = SCALE_2; end
            default: ;
        endcase
        diff_w = {sel_raw[W-1], sel_raw} - {sel_mean[W-1], sel_mean};
        prod_w = {{(W+1){diff_w[W]}}, diff_w} * {{(W+2){sel_scale[W-1]}}, sel_scale};
        shr_w  = prod_w >>> FRACTION_WIDTH;
        sat_w  = 1'b0;
        res_w  = shr_w[W-1:0];
        if (shr_w > MAX_V) begin
            sat_w = 1'b1;
            res_w = {1'b0, {(W-1){1'b1}}};
        end else if (shr_w < MIN_V) begin
            sat_w = 1'b1;
            res_w = {1'b1, {(W-1){1'b0}}};
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_err_d = 1'b0;
        store_en    = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (in_last && idx_q != 2'd2) begin
                        // Short frame: drop it and restart from feature 1.
                        idx_d       = 2'd0;
                        frame_err_d = 1'b1;
                    end else begin
                        store_en = 1'b1;
                        if (idx_q == 2'd2) begin
                            state_d     = SCALE;
                            idx_d       = 2'd0;
                            frame_err_d = !in_last;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end
            end
            SCALE: begin
                if (idx_q == 2'd2) begin
                    state_d = EMIT;
                    idx_d   = 2'd0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            EMIT:    state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            idx_q       <= 2'd0;
            for (int i = 0; i < 3; i++) raw_q[i] <= '0;
            for (int i = 0; i < 2; i++) res_q[i] <= '0;
            part_sat_q  <= 2'b00;
            inp1_q      <= '0;
            inp2_q      <= '0;
            inp3_q      <= '0;
            out_sat_q   <= 3'b000;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_err_q <= frame_err_d;
            out_valid_q <= (state_q == SCALE) && (idx_q == 2'd2);
            for (int i = 0; i < 3; i++) begin
                if (store_en && idx_q == 2'(i)) raw_q[i] <= in_data;
            end
            if (state_q == SCALE) begin
                case (idx_q)
                    2'd0: begin res_q[0] <= res_w; part_sat_q[0] <= sat_w; end
                    2'd1: begin res_q[1] <= res_w; part_sat_q[1] <= sat_w; end
                    default: begin
                        // All three outputs change together on entry to EMIT.
                        inp1_q    <= res_q[0];
                        inp2_q    <= res_q[1];
                        inp3_q    <= res_w;
                        out_sat_q <= {sat_w, part_sat_q};
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/mlp_feature_scaler.md
MLP_FEATURE_SCALER -- requirements
Module: mlp_feature_scaler

Interface
REQ-001 SHALL have parameter INTEGRAL_WIDTH, default 4, the integer bits of the signed fixed-point word.
REQ-002 SHALL have parameter FRACTION_WIDTH, default 16, the fraction bits; word width W = INTEGRAL_WIDTH + FRACTION_WIDTH.
REQ-003 SHALL have parameters MEAN_1, MEAN_2, MEAN_3, default 0, the per-feature offsets (signed, W bits).
REQ-004 SHALL have parameters SCALE_1, SCALE_2, SCALE_3, default 2^FRACTION_WIDTH (1.0), the per-feature gains (signed, W bits).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-007 SHALL have port in_data, input, W bits signed, one raw feature per beat, in order feature 1, 2, 3.
REQ-008 SHALL have port in_valid, input, 1 bit, marking in_data as valid.
REQ-009 SHALL have port in_last, input, 1 bit, a frame marker expected on the third feature.
REQ-010 SHALL have port in_ready, output, 1 bit; a beat is accepted on an edge where in_valid and in_ready are both 1.
REQ-011 SHALL have ports inp_1, inp_2, inp_3, output, W bits signed, the scaled features that feed the MLP inputs directly.
REQ-012 SHALL have port out_valid, output, 1 bit, a one-cycle pulse marking a new inp_1..3 triple.
REQ-013 SHALL have port out_sat, output, 3 bits, per-feature saturation flags for the current triple (bit0 = feature 1).
REQ-014 SHALL have port frame_err, output, 1 bit, a one-cycle framing-error pulse.

Function
REQ-015 SHALL implement FSM states COLLECT, SCALE and EMIT, with a 2-bit index idx.
REQ-016 COLLECT: in_ready=1; each accepted beat stores into raw[idx] and increments idx; acceptance at idx=2 moves the FSM to SCALE with idx=0.
REQ-017 SCALE: in_ready=0; one feature per cycle for idx 0,1,2 using one shared multiplier; after idx=2 the FSM moves to EMIT.
REQ-018 EMIT: in_ready=0 and out_valid=1 for exactly one cycle; inp_1..3 and out_sat update together on entry to EMIT; the next state is COLLECT.
REQ-019 Latency SHALL be fixed: out_valid is high in the 4th cycle after the edge that accepts feature 3.
REQ-020 Minimum sample period SHALL be 7 cycles.
REQ-021 Arithmetic, per feature k:
- d = in - MEAN_k, in W+1 bits;
- p = d * SCALE_k, in 2W+2 bits;
- r = p arithmetically shifted right by FRACTION_WIDTH (truncates toward minus infinity).
REQ-022 r SHALL saturate to [-2^(W-1), 2^(W-1)-1]; out_sat[k-1]=1 iff clamping occurred.
REQ-023 inp_1..3 and out_sat SHALL hold their values between EMIT cycles; the MLP samples them every cycle.
REQ-024 An accepted beat with in_last=1 at idx<2 SHALL be discarded: idx returns to 0, frame_err pulses next cycle, and stored raw values are ignored.
REQ-025 An accepted beat with in_last=0 at idx=2 SHALL still be processed normally, and frame_err SHALL pulse next cycle.
REQ-026 in_valid while in_ready=0 SHALL have no effect; the upstream holds the beat.

Reset
REQ-027 With rst=1 at an edge, the block SHALL set:
- state=COLLECT, idx=0;
- inp_1..3=0, out_sat=0, out_valid=0, frame_err=0;
- raw registers=0.
REQ-028 in_ready SHALL be 0 while rst=1, and 1 in the first cycle after rst falls.
REQ-029 rst asserted during SCALE or EMIT SHALL abort the sample: no out_valid, and inp_1..3 become 0.

Verification
REQ-030 Default parameters, beats 0x10000, 0xF0000, 0x00000 (last on the third) -> out_valid 4 cycles later; inp_1=0x10000, inp_2=0xF0000, inp_3=0; out_sat=000.
REQ-031 MEAN_1=0x08000, SCALE_1=0x20000, feature 1 = 0x18000 -> inp_1=0x20000, out_sat[0]=0.
REQ-032 SCALE_1=0x20000, feature 1 = 0x60000 -> inp_1=0x7FFFF, out_sat[0]=1; feature 1 = 0xA0000 -> inp_1=0x80000, out_sat[0]=1.
REQ-033 in_last on the second beat -> frame_err pulse, no out_valid; the next 3 well-framed beats produce a normal triple.
REQ-034 Back-to-back samples with in_valid held high -> in_ready low for 4 cycles after each third beat; out_valid period is 7 cycles.
REQ-035 rst pulsed one cycle during SCALE -> no out_valid, inp_1..3=0, in_ready=1 the cycle after rst falls.
